// File: rtl/washing_machine_pkg.sv
// Shared constants and types for the washing machine plant emulator.
// The pass counter type is an enum so waveforms show the drum's pass.
package washing_machine_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        DRAIN_NONE   = 2'd0,
        DRAIN_FIRST  = 2'd1,
        DRAIN_SECOND = 2'd2
    } drain_cnt_e;

    // Saturating advance of the pass counter; SECOND is terminal.
    function automatic drain_cnt_e next_drain(input drain_cnt_e cur);
        drain_cnt_e nxt;
        case (cur)
            DRAIN_NONE:  nxt = DRAIN_FIRST;
            DRAIN_FIRST: nxt = DRAIN_SECOND;
            default:     nxt = DRAIN_SECOND;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wm_sat_timer.sv
// Pausable cycle timer: counts qualified cycles, latches done at TERM and
// then holds until cleared.
module wm_sat_timer
    import washing_machine_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int TERM  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [CNT_W-1:0] cnt_q;

    // clr wins over en so a restart edge discards that cycle's qualified event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (en && !done) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TERM - 1)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/washing_machine_plant_model.sv
// Plant/sensor emulator for the washing machine controller: water level,
// pass counter, three process timers, door sensor and sticky abuse flag.
module washing_machine_plant_model
    import washing_machine_pkg::*;
#(
    parameter int LEVEL_MAX   = 8,
    parameter int DET_CYCLES  = 3,
    parameter int WASH_CYCLES = 10,
    parameter int SPIN_CYCLES = 6,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_valve_on,
    input  logic             detergent_valve_on,
    input  logic             motor_on,
    input  logic             drain_valve_on,
    input  logic             spin_motor_on,
    input  logic             door_lock,
    input  logic             door_open_req,
    output logic             door_close,
    output logic             filled,
    output logic             detergent_added,
    output logic             wash_done,
    output logic             drained_1,
    output logic             rinse_filled,
    output logic             drained_2,
    output logic             spin_done,
    output logic             fault,
    output logic [CNT_W-1:0] water_level
);

    logic [CNT_W-1:0] level_q;
    drain_cnt_e       drain_q;
    logic             lock_q;
    logic             door_close_q;
    logic             fault_q;

    logic at_full;
    logic at_empty;
    logic fill_only;
    logic drain_only;
    logic restart;
    logic abuse;

    assign at_full    = (level_q == CNT_W'(LEVEL_MAX));
    assign at_empty   = (level_q == '0);
    assign fill_only  = fill_valve_on && !drain_valve_on;
    assign drain_only = drain_valve_on && !fill_valve_on;
    // Falling edge of the lock, seen against the previous sampled value.
    assign restart    = lock_q && !door_lock;

    assign abuse = (spin_motor_on && !at_empty)
                 || (motor_on && !door_lock)
                 || (fill_valve_on && !door_lock)
                 || (door_open_req && door_lock);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
        end else if (fill_only && !at_full) begin
            level_q <= level_q + 1'b1;
        end else if (drain_only && !at_empty) begin
            level_q <= level_q - 1'b1;
        end
    end

    // A pass completes only on the 1->0 step; draining an empty drum is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_q <= DRAIN_NONE;
        end else if (restart) begin
            drain_q <= DRAIN_NONE;
        end else if (drain_only && (level_q == CNT_W'(1))) begin
            drain_q <= next_drain(drain_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q       <= 1'b0;
            door_close_q <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            lock_q       <= door_lock;
            door_close_q <= door_lock || !door_open_req;
            if (abuse) begin
                fault_q <= 1'b1;
            end
        end
    end

    wm_sat_timer #(
        .CNT_W (CNT_W),
        .TERM  (DET_CYCLES)
    ) u_det_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .en    (detergent_valve_on && at_full),
        .done  (detergent_added)
    );

    wm_sat_timer #(
        .CNT_W (CNT_W),
        .TERM  (WASH_CYCLES)
    ) u_wash_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .en    (motor_on && !at_empty),
        .done  (wash_done)
    );

    wm_sat_timer #(
        .CNT_W (CNT_W),
        .TERM  (SPIN_CYCLES)
    ) u_spin_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .en    (spin_motor_on && at_empty),
        .done  (spin_done)
    );

    // Sensor flags decode registered state only.
    assign water_level  = level_q;
    assign filled       = at_full && (drain_q == DRAIN_NONE);
    assign rinse_filled = at_full && (drain_q == DRAIN_FIRST);
    assign drained_1    = (drain_q != DRAIN_NONE);
    assign drained_2    = (drain_q == DRAIN_SECOND);
    assign door_close   = door_close_q;
    assign fault        = fault_q;

endmodule

// File: doc/washing_machine_plant_model.md
# washing_machine_plant_model

Synthesizable plant and sensor emulator for the automatic washing machine controller. It sits on the controller's actuator/sensor boundary as the responder: it consumes the valve, motor and lock commands and produces the fill, detergent, wash, drain and spin sensor flags the controller waits on. Responses come from cycle-count timers, so the controller can be closed-loop tested in simulation and on FPGA without a physical drum.

## Interface
- `LEVEL_MAX`, 8: water-level counts from empty to full. One count per cycle of filling or draining.
- `DET_CYCLES`, 3: cycles of `detergent_valve_on` with a full drum before `detergent_added`.
- `WASH_CYCLES`, 10: cycles of `motor_on` with water present before `wash_done`.
- `SPIN_CYCLES`, 6: cycles of `spin_motor_on` with an empty drum before `spin_done`.
- `CNT_W`, 8: width of all internal counters. Each of the four parameters above must be in 1..2^CNT_W-1.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `fill_valve_on` input 1: controller command, fill valve open.
- `detergent_valve_on` input 1: controller command, detergent valve open.
- `motor_on` input 1: controller command, wash agitation.
- `drain_valve_on` input 1: controller command, drain valve open.
- `spin_motor_on` input 1: controller command, spin motor.
- `door_lock` input 1: controller command, door locked.
- `door_open_req` input 1: stimulus representing a user opening the door.
- `door_close` output 1: door-closed sensor.
- `filled` output 1: drum full, wash pass.
- `detergent_added` output 1: detergent dose complete.
- `wash_done` output 1: agitation complete.
- `drained_1` output 1: first empty-out complete.
- `rinse_filled` output 1: drum full, rinse pass.
- `drained_2` output 1: second empty-out complete.
- `spin_done` output 1: spin complete.
- `fault` output 1: sticky plant-abuse flag.
- `water_level` output CNT_W: current level, for observability.

## Operation
**Reset.** While `reset` = 0, all counters, flags and `fault` are 0 and `water_level` = 0. `door_close` = 1 during reset.

**Water level.**
- Fill only: level +1, saturating at LEVEL_MAX.
- Drain only: level −1, saturating at 0.
- Both valves open, or neither: level holds.

**Pass counter `drain_cnt` (0..2, saturating).**
- Increments on the cycle the level steps from 1 to 0 under drain.
- Draining an already-empty drum does not increment it.

**Sensor flags.**
- `filled` = (level == LEVEL_MAX) && `drain_cnt` == 0.
- `rinse_filled` = (level == LEVEL_MAX) && `drain_cnt` == 1.
- `drained_1` = `drain_cnt` ≥ 1.
- `drained_2` = `drain_cnt` == 2.
- `drained_1` and `drained_2` are sticky.

**Timers.** Each timer counts only while its qualifier holds. It pauses, and does not clear, when the qualifier drops. When it reaches its terminal count it sets a sticky flag and stops counting.
- Detergent: qualifier `detergent_valve_on` && level == LEVEL_MAX; sets `detergent_added`.
- Wash: qualifier `motor_on` && level > 0; sets `wash_done`.
- Spin: qualifier `spin_motor_on` && level == 0; sets `spin_done`.

**Door.**
- `door_close` = ~`door_open_req` while `door_lock` = 0.
- While `door_lock` = 1, `door_close` is forced to 1.

**Cycle restart.** A 1→0 edge of `door_lock` clears `drain_cnt`, all three timers and all sticky sensor flags. It does not clear the level or `fault`.

**Fault (sticky, cleared only by reset).** `fault` sets on any of:
- `spin_motor_on` && level > 0.
- `motor_on` && `door_lock` = 0.
- `fill_valve_on` && `door_lock` = 0.
- `door_open_req` && `door_lock` = 1.

A fault does not stop the plant model.

## Timing
- All state updates on the `clk` rising edge.
- Every output is decoded from registers only. There is no combinational input→output path.
- **Fill:** starting from empty, with `fill_valve_on` held from cycle 0, `filled` is visible after the LEVEL_MAX-th edge.
- **Timers:** a flag asserts after exactly N qualified edges (N = DET_CYCLES, WASH_CYCLES or SPIN_CYCLES).
- **Restart:** the clear takes effect on the edge after `door_lock` is sampled 0 following a sampled 1. Events qualified on that same edge are discarded.
- **Reset mid-operation:** asynchronous return to reset values. Counting resumes on the first edge after deassertion.

## Structure
- **Package `washing_machine_pkg`:**
  - CNT_W default.
  - Pass-count constants: DRAIN_NONE = 0, DRAIN_FIRST = 1, DRAIN_SECOND = 2.
- **Sub-module `wm_sat_timer`:**
  - Ports: clk, reset, clr, en → done.
  - Parameter: TERM.
  - Instantiated three times: detergent, wash, spin.
- **Top level:** level counter, pass counter, door logic and fault logic.

## Test plan
All scenarios use the default parameters.
1. **Full program:** reset, lock, fill 8 cycles → `filled` = 1 at level 8. Detergent 3 cycles → `detergent_added`. Motor 10 cycles → `wash_done`. Drain 8 → `drained_1`, `filled` = 0. Fill 8 → `rinse_filled`. Drain 8 → `drained_2`. Spin 6 → `spin_done`. `fault` stays 0 throughout.
2. **Simultaneous valves:** fill and drain asserted together at level 4 for 5 cycles → level stays 4. Drain at level 0 for 3 cycles → `drain_cnt` stays 0.
3. **Timer pause:** motor 6 cycles, off 4, on 4 → `wash_done` rises on the 10th qualified edge, not earlier.
4. **Spin with water:** `spin_motor_on` at level 3 → `fault` = 1 next edge, and the spin timer does not advance.
5. **Restart:** after scenario 1, drop `door_lock` → all sensor flags 0 next edge; level and `fault` unchanged.
6. **Reset mid-fill:** `reset` low at level 5 → level 0 and all flags 0 immediately. Refill needs a full 8 cycles.
